vecmac_acc_stage: RTL and testbench

- Downstream consumer of the 5-cycle int8 Wallace multiplier/adder-tree stage (mul1x8x8_wallace).
- Accumulates the stream of 18-bit per-beat partial sums into one ACC_W-bit dot-product result over cfg_len beats.
- Queues finished results in a small FIFO behind a ready/valid output.
- The multiplier pipeline cannot stall, so this block drives an issue-permission signal that the upstream issuer must honour.

---
 rtl/vecmac_acc_stage_pkg.sv | 22 ++
 rtl/vecmac_res_fifo.sv | 72 +++++++
 rtl/vecmac_acc_stage.sv | 158 +++++++++++++++
 tb/tb_vecmac_acc_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vecmac_acc_stage_pkg.sv
// ============================================================
// Package : vecmac_acc_stage_pkg
// Brief   : Shared widths, upstream latency and FSM encoding
// Revision: 1.0
// ============================================================
`default_nettype none

package vecmac_acc_stage_pkg;

    localparam int IN_W_DEF   = 18;
    localparam int ACC_W_DEF  = 32;
    // Latency of mul1x8x8_wallace; issue gating depends on it.
    localparam int UP_LAT_DEF = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vecmac_res_fifo.sv
// ============================================================
// Module  : vecmac_res_fifo
// Brief   : First-word-fall-through result FIFO with occupancy count
// Revision: 1.0
// ============================================================
`default_nettype none

module vecmac_res_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_full;
    logic w_push_ok;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pop     = (r_count != '0) && out_ready;
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_push_ok = push && (!w_full || w_pop);

    assign drop      = push && !w_push_ok;
    assign count     = r_count;
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vecmac_acc_stage.sv
// ============================================================
// Module  : vecmac_acc_stage
// Brief   : Dot-product accumulator behind the Wallace multiplier stage
// Revision: 1.0
// ============================================================
`default_nettype none

module vecmac_acc_stage
    import vecmac_acc_stage_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int UP_LAT     = UP_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_sum,
    output logic             issue_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic             err_drop,
    output logic             busy
);

    localparam int SUM_W = ACC_W + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_err_drop;

    logic [ACC_W-1:0] w_in_ext;
    logic [SUM_W-1:0] w_sum;
    logic [ACC_W-1:0] w_add_acc;
    logic             w_add_sat;
    logic [LEN_W-1:0] w_len_cfg;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_push;
    logic [ACC_W-1:0] w_push_acc;
    logic             w_push_sat;
    logic             w_load;
    logic             w_step;
    logic             w_drop;
    logic [ACC_W:0]   w_head;
    logic [CW-1:0]    w_count;

    // One extra bit catches the carry; overflow clamps and marks the group.
    always_comb begin
        w_in_ext  = ACC_W'(in_sum);
        w_sum     = SUM_W'(r_acc) + SUM_W'(in_sum);
        w_add_acc = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        w_add_sat = r_sat | w_sum[ACC_W];
        w_len_cfg = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        w_cnt_inc = r_cnt + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_acc  = w_add_acc;
        w_push_sat  = w_add_sat;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_len_cfg == LEN_W'(1)) begin
                        w_push     = 1'b1;
                        w_push_acc = w_in_ext;
                        w_push_sat = 1'b0;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    if (w_cnt_inc == r_len) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_err_drop <= 1'b0;
        end else begin
            if (w_load) begin
                r_acc <= w_in_ext;
                r_sat <= 1'b0;
                r_len <= w_len_cfg;
                r_cnt <= LEN_W'(1);
            end
            if (w_step) begin
                r_acc <= w_add_acc;
                r_sat <= w_add_sat;
                r_cnt <= w_cnt_inc;
            end
            if (w_drop) begin
                r_err_drop <= 1'b1;
            end
        end
    end

    vecmac_res_fifo #(
        .WIDTH (ACC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({w_push_sat, w_push_acc}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (w_head),
        .count     (w_count),
        .drop      (w_drop)
    );

    // Leaves room for every beat already launched into the multiplier.
    assign issue_ok = (w_count <= CW'(FIFO_DEPTH - 1 - UP_LAT));
    assign out_acc  = w_head[ACC_W-1:0];
    assign out_sat  = w_head[ACC_W];
    assign err_drop = r_err_drop;
    assign busy     = (r_state == ST_ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_vecmac_acc_stage.sv
// ============================================================
// Module  : tb_vecmac_acc_stage
// Brief   : Directed + random bench for 32-bit and 18-bit accumulator builds
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_vecmac_acc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_len;
    logic        in_valid;
    logic [17:0] in_sum;
    logic        out_ready;

    logic        issue_ok_a, out_valid_a, out_sat_a, err_drop_a, busy_a;
    logic [31:0] out_acc_a;
    logic        issue_ok_b, out_valid_b, out_sat_b, err_drop_b, busy_b;
    logic [17:0] out_acc_b;

    int checks   = 0;
    int failures = 0;

    longint unsigned q[$];
    bit              m_in_group;
    bit              m_drop;
    longint unsigned m_sum;
    int              m_len;
    int              m_n;

    logic        pv [6];
    logic [17:0] pd [6];
    logic [17:0] sb [4];

    always #5 clk = ~clk;

    vecmac_acc_stage u_dut_a (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_sum(in_sum),
        .issue_ok(issue_ok_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_acc(out_acc_a), .out_sat(out_sat_a), .err_drop(err_drop_a), .busy(busy_a)
    );

    vecmac_acc_stage #(.ACC_W(18)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_sum(in_sum),
        .issue_ok(issue_ok_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_acc(out_acc_b), .out_sat(out_sat_b), .err_drop(err_drop_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned clamp(input longint unsigned s, input int w);
        longint unsigned mx = (64'd1 << w) - 64'd1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic compare_all();
        longint unsigned h;
        bit              v;
        v = (q.size() != 0);
        h = v ? q[0] : 64'd0;
        check("valid32", out_valid_a, v);
        check("valid18", out_valid_b, v);
        check("issue32", issue_ok_a, q.size() <= 2);
        check("issue18", issue_ok_b, q.size() <= 2);
        check("busy32", busy_a, m_in_group);
        check("busy18", busy_b, m_in_group);
        check("drop32", err_drop_a, m_drop);
        check("drop18", err_drop_b, m_drop);
        check("acc32", out_acc_a, clamp(h, 32));
        check("sat32", out_sat_a, h > 64'hFFFF_FFFF);
        check("acc18", out_acc_b, clamp(h, 18));
        check("sat18", out_sat_b, h > 64'h3_FFFF);
    endtask

    // Group-level model: true sums are queued; each build clamps at compare time.
    task automatic tick();
        bit pop;
        bit done;
        done = 1'b0;
        if (rst) begin
            q.delete();
            m_in_group = 1'b0;
            m_drop     = 1'b0;
        end else begin
            pop = out_ready && (q.size() != 0);
            if (in_valid) begin
                if (!m_in_group) begin
                    m_len = (cfg_len == 16'd0) ? 1 : int'(cfg_len);
                    m_sum = longint'(in_sum);
                    m_n   = 1;
                end else begin
                    m_sum = m_sum + longint'(in_sum);
                    m_n   = m_n + 1;
                end
                if (m_n == m_len) begin
                    done       = 1'b1;
                    m_in_group = 1'b0;
                end else begin
                    m_in_group = 1'b1;
                end
            end
            if (pop) void'(q.pop_front());
            if (done) begin
                if (q.size() < 8) q.push_back(m_sum);
                else m_drop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Upstream issuer with the multiplier's 5-cycle latency.
    task automatic up_cycle(input bit allow);
        for (int k = 5; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0]    = allow && issue_ok_a;
        pd[0]    = 18'($urandom());
        in_valid = pv[5];
        in_sum   = pd[5];
        tick();
    endtask

    initial begin
        rst = 1'b1; cfg_len = 16'd1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
        m_in_group = 1'b0; m_drop = 1'b0; m_sum = 0; m_len = 1; m_n = 0;
        for (int k = 0; k < 6; k++) begin pv[k] = 1'b0; pd[k] = '0; end
        sb[0] = 18'h00000; sb[1] = 18'h0FE01; sb[2] = 18'h0007F; sb[3] = 18'h04000;

        tick();
        tick();
        check("rst_issue", issue_ok_a, 1'b1);
        check("rst_valid", out_valid_a, 1'b0);
        rst = 1'b0;
        tick();

        // Single-beat groups: each result visible one cycle after its beat.
        cfg_len = 16'd1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = sb[i];
            tick();
            check("single_valid", out_valid_a, 1'b1);
            check("single_acc", out_acc_a, sb[i]);
            in_valid = 1'b0;
            tick();
        end

        // Four beats with two idle cycles between them.
        cfg_len = 16'd4;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = 18'h0FE01;
            tick();
            in_valid = 1'b0;
            if (i < 3) begin
                check("gap_busy", busy_a, 1'b1);
                tick();
                tick();
            end
        end
        check("gap_acc", out_acc_a, 32'h3F804);
        check("gap_busy_end", busy_a, 1'b0);
        tick();

        // Saturation in the 18-bit build, then a clean group.
        cfg_len = 16'd3;
        in_valid = 1'b1;
        in_sum = 18'h3FFFF; tick();
        in_sum = 18'h00001; tick();
        in_sum = 18'h00005; tick();
        check("sat_acc18", out_acc_b, 18'h3FFFF);
        check("sat_flag18", out_sat_b, 1'b1);
        in_valid = 1'b0; tick();
        cfg_len = 16'd1; in_valid = 1'b1; in_sum = 18'h00007; tick();
        check("post_acc18", out_acc_b, 18'h00007);
        check("post_sat18", out_sat_b, 1'b0);
        in_valid = 1'b0; tick();

        // Backpressure with an issuer that honours issue_ok.
        out_ready = 1'b0; cfg_len = 16'd1;
        for (int i = 0; i < 30; i++) up_cycle(1'b1);
        check("bp_full_valid", out_valid_a, 1'b1);
        check("bp_issue_low", issue_ok_a, 1'b0);
        check("bp_no_drop", err_drop_a, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) up_cycle(1'b0);

        // Full FIFO: push with pop accepted, push without pop dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) up_cycle(1'b1);
        in_valid = 1'b1; in_sum = 18'($urandom()); out_ready = 1'b1;
        tick();
        check("pp_no_drop", err_drop_a, 1'b0);
        in_sum = 18'($urandom()); out_ready = 1'b0;
        tick();
        check("force_drop", err_drop_a, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();

        // Reset in the middle of a group discards it.
        cfg_len = 16'd4; in_valid = 1'b1;
        in_sum = 18'h00123; tick();
        in_sum = 18'h00456; tick();
        in_valid = 1'b0; rst = 1'b1; tick();
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_valid", out_valid_a, 1'b0);
        rst = 1'b0; cfg_len = 16'd2; in_valid = 1'b1;
        in_sum = 18'h00010; tick();
        in_sum = 18'h00020; tick();
        check("midrst_acc", out_acc_a, 32'h30);
        in_valid = 1'b0; tick();

        // Random traffic, including cfg_len changes mid-group and drops.
        for (int i = 0; i < 400; i++) begin
            cfg_len   = 16'($urandom_range(0, 4));
            in_valid  = 1'($urandom_range(0, 1));
            in_sum    = 18'($urandom());
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
